accu_cpu_core: RTL and testbench

//  Parametrised accumulator CPU core; successor to the fixed 8-bit PC/decoder/regfile/ALU/CY/A datapath.

---
 rtl/accu_cpu_core_if.sv | 24 ++
 rtl/accu_cpu_core.sv | 157 +++++++++++++++
 tb/tb_accu_cpu_core.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accu_cpu_core_if.sv
// Instruction-memory fetch port of the accumulator core.
// The core drives the address and read strobe; memory returns data/valid.
interface accu_cpu_core_if #(
  parameter int PC_W = 5
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [PC_W+3:0] imem_data;
  logic            imem_valid;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_data,
    output imem_valid
  );
endinterface

// File: rtl/accu_cpu_core.sv
// Accumulator CPU core: PC, IR, register file, ALU, CY and A behind a FETCH/EXEC FSM.
// Optional ACCU_CORE_STEP_EN adds a `step` input and a PAUSE state for single-stepping.
module accu_cpu_core #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 16,
  parameter int PC_W   = 5
) (
  input  logic              clk,
  input  logic              Reset,
  accu_cpu_core_if.master   imem,
  output logic [DATA_W-1:0] acc,
  output logic              cy,
  output logic              retire,
`ifdef ACCU_CORE_STEP_EN
  output logic              halted,
  input  logic              step
`else
  output logic              halted
`endif
);

  localparam int IDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_PAUSE
  } state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W+3:0]   ir_q;
  logic [DATA_W-1:0] a_q;
  logic              cy_q;
  logic              rd_q;
  logic              retire_q;
  logic              halted_q;
  logic [DATA_W-1:0] regs_q [REG_N];

  logic [3:0]        op;
  logic [PC_W-1:0]   opnd;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] a_d;
  logic              cy_d;
  logic [PC_W-1:0]   pc_d;
  logic              rf_we;
  logic              halt_d;
  logic [DATA_W:0]   sum;

  assign op   = ir_q[PC_W+3:PC_W];
  assign opnd = ir_q[PC_W-1:0];
  assign idx  = opnd[IDX_W-1:0];
  assign r    = regs_q[idx];

  assign imem.imem_addr = pc_q;
  assign imem.imem_rd   = rd_q;
  assign acc            = a_q;
  assign cy             = cy_q;
  assign retire         = retire_q;
  assign halted         = halted_q;

  // Decode IR and compute the architectural state committed at the end of EXEC.
  always_comb begin
    a_d    = a_q;
    cy_d   = cy_q;
    pc_d   = pc_q + PC_W'(1);
    rf_we  = 1'b0;
    halt_d = 1'b0;
    sum    = '0;
    unique case (op)
      4'h1: a_d = r;
      4'h2: rf_we = 1'b1;
      4'h3: begin
        sum = {1'b0, a_q} + {1'b0, r};
        {cy_d, a_d} = sum;
      end
      4'h4: begin
        sum = {1'b0, a_q} + {1'b0, r} + {{DATA_W{1'b0}}, cy_q};
        {cy_d, a_d} = sum;
      end
      4'h5: begin
        sum = {1'b0, a_q} - {1'b0, r};
        {cy_d, a_d} = sum;
      end
      4'h6: a_d = a_q & r;
      4'h7: a_d = a_q | r;
      4'h8: a_d = a_q ^ r;
      4'h9: cy_d = 1'b0;
      4'hA: pc_d = opnd;
      4'hB: if (a_q == '0) pc_d = opnd;
      4'hC: if (cy_q) pc_d = opnd;
      4'hD: a_d = DATA_W'(opnd);
      4'hE: {cy_d, a_d} = {a_q, 1'b0};
      4'hF: begin
        halt_d = 1'b1;
        pc_d   = pc_q;
      end
      default: ;
    endcase
  end

  // FSM, registered outputs and all architectural state; Reset wins over everything.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      cy_q     <= 1'b0;
      rd_q     <= 1'b1;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (imem.imem_valid) begin
            ir_q     <= imem.imem_data;
            state_q  <= S_EXEC;
            rd_q     <= 1'b0;
            retire_q <= 1'b1;
          end
        end
        S_EXEC: begin
          retire_q <= 1'b0;
          a_q      <= a_d;
          cy_q     <= cy_d;
          pc_q     <= pc_d;
          if (rf_we) regs_q[idx] <= a_q;
          if (halt_d) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
`ifdef ACCU_CORE_STEP_EN
            state_q <= S_PAUSE;
`else
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
`endif
          end
        end
`ifdef ACCU_CORE_STEP_EN
        S_PAUSE: begin
          if (step) begin
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accu_cpu_core.sv
// Directed bench for accu_cpu_core with a per-retire scoreboard.
// Expected post-commit A/CY/PC are queued as each program is loaded.
module tb_accu_cpu_core;

  typedef struct {
    logic [7:0] a;
    logic       c;
    logic [4:0] pc;
  } exp_t;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       step = 1'b1;
  logic [7:0] acc;
  logic       cy;
  logic       retire;
  logic       halted;
  logic [8:0] prog [32];
  exp_t       sb [$];
  exp_t       e;
  int         n_checks = 0;
  int         n_errors = 0;
  int         retire_cnt = 0;

  accu_cpu_core_if #(.PC_W(5)) ifc ();

  assign ifc.imem_data = prog[ifc.imem_addr];

  accu_cpu_core #(.DATA_W(8), .REG_N(16), .PC_W(5)) dut (
    .clk    (clk),
    .Reset  (Reset),
    .imem   (ifc),
    .acc    (acc),
    .cy     (cy),
    .retire (retire),
`ifdef ACCU_CORE_STEP_EN
    .halted (halted),
    .step   (step)
`else
    .halted (halted)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] o);
    return {op, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic c, input logic [4:0] pc);
    exp_t x;
    x.a = a;
    x.c = c;
    x.pc = pc;
    sb.push_back(x);
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 32; i++) prog[i] = 9'h000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    retire_cnt = 0;
    Reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || halted !== 1'b1) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, {31'd0, sb.size() == 0 && halted === 1'b1}, 32'd1);
  endtask

  task automatic wait_fetch(input logic [4:0] pc, input int max);
    int n;
    n = 0;
    while (!(ifc.imem_addr === pc && ifc.imem_rd === 1'b1) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_fetch", {31'd0, ifc.imem_addr === pc && ifc.imem_rd === 1'b1}, 32'd1);
  endtask

  // Scoreboard: on each committed retire compare A, CY and next fetch address.
  always @(posedge clk) begin
    if (retire === 1'b1 && Reset === 1'b0) begin
      #1;
      retire_cnt++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_acc", {24'd0, acc}, {24'd0, e.a});
        chk("sb_cy", {31'd0, cy}, {31'd0, e.c});
        chk("sb_pc", {27'd0, ifc.imem_addr}, {27'd0, e.pc});
      end
    end
  end

  initial begin
    ifc.imem_valid = 1'b1;
    clr_prog();

    // Reset state
    do_reset();
    chk("rst_acc", {24'd0, acc}, 32'd0);
    chk("rst_cy", {31'd0, cy}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_rd", {31'd0, ifc.imem_rd}, 32'd1);
    chk("rst_addr", {27'd0, ifc.imem_addr}, 32'd0);

    // Test 1: LDI 7; STR 3; LDI 9; ADD 3; HALT
    clr_prog();
    prog[0] = ins(4'hD, 5'd7);
    prog[1] = ins(4'h2, 5'd3);
    prog[2] = ins(4'hD, 5'd9);
    prog[3] = ins(4'h3, 5'd3);
    prog[4] = ins(4'hF, 5'd0);
    do_reset();
    push(8'h07, 1'b0, 5'd1);
    push(8'h07, 1'b0, 5'd2);
    push(8'h09, 1'b0, 5'd3);
    push(8'h10, 1'b0, 5'd4);
    push(8'h10, 1'b0, 5'd4);
`ifndef ACCU_CORE_STEP_EN
    repeat (9) @(posedge clk);
    #1;
    chk("t1_halt_c9", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_halt_c10", {31'd0, halted}, 32'd1);
`endif
    drain("t1", 40);
    repeat (5) @(negedge clk);
    chk("t1_acc", {24'd0, acc}, 32'h10);
    chk("t1_cy", {31'd0, cy}, 32'd0);
    chk("t1_addr", {27'd0, ifc.imem_addr}, 32'd4);
    chk("t1_rd", {31'd0, ifc.imem_rd}, 32'd0);
    chk("t1_retires", retire_cnt, 32'd5);

    // Test 2: shifts, ADD with carry out, ADC consuming it
    clr_prog();
    prog[0] = ins(4'hD, 5'd31);
    prog[1] = ins(4'hE, 5'd0);
    prog[2] = ins(4'hE, 5'd0);
    prog[3] = ins(4'hE, 5'd0);
    prog[4] = ins(4'h2, 5'd2);
    prog[5] = ins(4'h3, 5'd2);
    prog[6] = ins(4'h4, 5'd0);
    prog[7] = ins(4'hF, 5'd0);
    do_reset();
    push(8'h1F, 1'b0, 5'd1);
    push(8'h3E, 1'b0, 5'd2);
    push(8'h7C, 1'b0, 5'd3);
    push(8'hF8, 1'b0, 5'd4);
    push(8'hF8, 1'b0, 5'd5);
    push(8'hF0, 1'b1, 5'd6);
    push(8'hF1, 1'b0, 5'd7);
    push(8'hF1, 1'b0, 5'd7);
    drain("t2", 60);

    // Test 3a: SUB borrow then taken JC
    clr_prog();
    prog[0]  = ins(4'hD, 5'd3);
    prog[1]  = ins(4'h2, 5'd1);
    prog[2]  = ins(4'hD, 5'd2);
    prog[3]  = ins(4'h5, 5'd1);
    prog[4]  = ins(4'hC, 5'd20);
    prog[20] = ins(4'hF, 5'd0);
    do_reset();
    push(8'h03, 1'b0, 5'd1);
    push(8'h03, 1'b0, 5'd2);
    push(8'h02, 1'b0, 5'd3);
    push(8'hFF, 1'b1, 5'd4);
    push(8'hFF, 1'b1, 5'd20);
    push(8'hFF, 1'b1, 5'd20);
    drain("t3a", 50);

    // Test 3b: CLC before JC makes it fall through
    clr_prog();
    prog[0]  = ins(4'hD, 5'd3);
    prog[1]  = ins(4'h2, 5'd1);
    prog[2]  = ins(4'hD, 5'd2);
    prog[3]  = ins(4'h5, 5'd1);
    prog[4]  = ins(4'h9, 5'd0);
    prog[5]  = ins(4'hC, 5'd20);
    prog[6]  = ins(4'hF, 5'd0);
    do_reset();
    push(8'h03, 1'b0, 5'd1);
    push(8'h03, 1'b0, 5'd2);
    push(8'h02, 1'b0, 5'd3);
    push(8'hFF, 1'b1, 5'd4);
    push(8'hFF, 1'b0, 5'd5);
    push(8'hFF, 1'b0, 5'd6);
    push(8'hFF, 1'b0, 5'd6);
    drain("t3b", 50);

    // Test 4: imem_valid low for 3 cycles while fetching address 1
    clr_prog();
    prog[0] = ins(4'hD, 5'd5);
    prog[1] = ins(4'hD, 5'd6);
    prog[2] = ins(4'hF, 5'd0);
    do_reset();
    push(8'h05, 1'b0, 5'd1);
    wait_fetch(5'd1, 10);
    ifc.imem_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_addr", {27'd0, ifc.imem_addr}, 32'd1);
      chk("t4_acc", {24'd0, acc}, 32'h05);
      chk("t4_retire", {31'd0, retire}, 32'd0);
    end
    ifc.imem_valid = 1'b1;
    push(8'h06, 1'b0, 5'd2);
    push(8'h06, 1'b0, 5'd2);
    @(negedge clk);
    chk("t4_resume", {31'd0, retire}, 32'd1);
    drain("t4", 30);

    // Test 5: JZ taken, untaken JZ, JMP 31, PC wrap 31 -> 0
    clr_prog();
    prog[0]  = ins(4'hD, 5'd0);
    prog[1]  = ins(4'hB, 5'd9);
    prog[9]  = ins(4'hD, 5'd1);
    prog[10] = ins(4'hB, 5'd3);
    prog[11] = ins(4'hA, 5'd31);
    prog[31] = ins(4'h0, 5'd0);
    do_reset();
    push(8'h00, 1'b0, 5'd1);
    push(8'h00, 1'b0, 5'd9);
    push(8'h01, 1'b0, 5'd10);
    push(8'h01, 1'b0, 5'd11);
    push(8'h01, 1'b0, 5'd31);
    push(8'h01, 1'b0, 5'd0);
    push(8'h01, 1'b0, 5'd0);
    repeat (2) @(negedge clk);
    prog[0] = ins(4'hF, 5'd0);
    drain("t5", 60);

    // Test 6: Reset during EXEC of ADD discards it and clears registers
    clr_prog();
    prog[0] = ins(4'hD, 5'd5);
    prog[1] = ins(4'h2, 5'd4);
    prog[2] = ins(4'h3, 5'd4);
    prog[3] = ins(4'hF, 5'd0);
    do_reset();
    push(8'h05, 1'b0, 5'd1);
    push(8'h05, 1'b0, 5'd2);
    wait_fetch(5'd2, 20);
    @(negedge clk);
    chk("t6_in_exec", {31'd0, retire}, 32'd1);
    Reset = 1'b1;
    sb.delete();
    @(negedge clk);
    Reset = 1'b0;
    chk("t6_acc", {24'd0, acc}, 32'd0);
    chk("t6_cy", {31'd0, cy}, 32'd0);
    chk("t6_addr", {27'd0, ifc.imem_addr}, 32'd0);
    chk("t6_rd", {31'd0, ifc.imem_rd}, 32'd1);
    chk("t6_retire", {31'd0, retire}, 32'd0);
    clr_prog();
    prog[0] = ins(4'h1, 5'd4);
    prog[1] = ins(4'hF, 5'd0);
    push(8'h00, 1'b0, 5'd1);
    push(8'h00, 1'b0, 5'd1);
    drain("t6", 20);

`ifdef ACCU_CORE_STEP_EN
    // Single-step: one retire, then one more per step pulse
    clr_prog();
    prog[0] = ins(4'hD, 5'd1);
    prog[1] = ins(4'hD, 5'd2);
    prog[2] = ins(4'hF, 5'd0);
    step = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    chk("st_one", retire_cnt, 32'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (8) @(negedge clk);
    chk("st_two", retire_cnt, 32'd2);
    chk("st_acc", {24'd0, acc}, 32'd2);
    step = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
